// File: rtl/esc_sequencer_if.sv
// Bundle between flight controller and ESC sequencer: arm level, command strobe, four speed commands.
// Latency: none (wires only); the sequencer registers every output it drives onto this bundle.
// Backpressure: none; cmd_vld is a single-cycle strobe that is always accepted.
interface esc_sequencer_if;
  logic        arm;
  logic        cmd_vld;
  logic [10:0] frnt_cmd;
  logic [10:0] bck_cmd;
  logic [10:0] lft_cmd;
  logic [10:0] rght_cmd;
  logic [10:0] frnt_spd;
  logic [10:0] bck_spd;
  logic [10:0] lft_spd;
  logic [10:0] rght_spd;
  logic        armed;
  logic        frm_tick;

  // Flight-controller side
  modport master (
    output arm, cmd_vld, frnt_cmd, bck_cmd, lft_cmd, rght_cmd,
    input  frnt_spd, bck_spd, lft_spd, rght_spd, armed, frm_tick
  );

  // Sequencer side
  modport slave (
    input  arm, cmd_vld, frnt_cmd, bck_cmd, lft_cmd, rght_cmd,
    output frnt_spd, bck_spd, lft_spd, rght_spd, armed, frm_tick
  );
endinterface

// File: rtl/esc_sequencer.sv
// ESC arming sequencer: zero frames, spin-up to MIN_RUN, then per-frame slew toward commanded speeds.
// Latency: channel k updates at tick+2+k through one shared slew unit; disarm zeroes outputs on the next edge.
// Backpressure: none; commands are captured on any cmd_vld, last capture in a frame wins.
module esc_sequencer #(
  parameter int unsigned FRAME_WIDTH = 20,
  parameter logic [15:0] ARM_FRAMES  = 16'd64,
  parameter logic [10:0] MIN_RUN     = 11'h200,
  parameter logic [10:0] SLEW        = 11'h040
) (
  input  logic           clk,
  input  logic           rst_n,
  esc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARM_WAIT, SPIN, RUN} state_t;

  // Tick is registered, so it is raised from the count just before all ones.
  localparam logic [FRAME_WIDTH-1:0] TICK_PRE = {{(FRAME_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [FRAME_WIDTH-1:0] FRM_ONE  = {{(FRAME_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q;
  logic [FRAME_WIDTH-1:0] frm_cnt_q;
  logic                   frm_tick_q;
  logic [15:0]            arm_cnt_q;
  logic                   pass_act_q;
  logic [1:0]             pass_idx_q;
  logic                   armed_q;
  logic [10:0]            spd_q [4];
  logic [10:0]            tgt_q [4];
  logic [10:0]            cmd_w [4];
  logic [10:0]            cur_w;
  logic [10:0]            tgt_w;
  logic [10:0]            step_d;
  logic                   all_min_d;

  // Targets never fall below the minimum run speed.
  function automatic logic [10:0] clamp_min(input logic [10:0] c);
    return (c < MIN_RUN) ? MIN_RUN : c;
  endfunction

  assign cmd_w[0] = bus.frnt_cmd;
  assign cmd_w[1] = bus.bck_cmd;
  assign cmd_w[2] = bus.lft_cmd;
  assign cmd_w[3] = bus.rght_cmd;

  assign bus.frnt_spd = spd_q[0];
  assign bus.bck_spd  = spd_q[1];
  assign bus.lft_spd  = spd_q[2];
  assign bus.rght_spd = spd_q[3];
  assign bus.armed    = armed_q;
  assign bus.frm_tick = frm_tick_q;

  // Shared slew unit: steps the channel selected by pass_idx_q toward its target without overshoot.
  always_comb begin
    cur_w  = spd_q[pass_idx_q];
    tgt_w  = (state_q == SPIN) ? MIN_RUN : tgt_q[pass_idx_q];
    step_d = cur_w;
    if (cur_w < tgt_w) begin
      step_d = ((tgt_w - cur_w) > SLEW) ? (cur_w + SLEW) : tgt_w;
    end else if (cur_w > tgt_w) begin
      step_d = ((cur_w - tgt_w) > SLEW) ? (cur_w - SLEW) : tgt_w;
    end
  end

  // All four channels at MIN_RUN, counting the value the slew unit is writing this cycle.
  always_comb begin
    all_min_d = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == int'(pass_idx_q)) begin
        all_min_d = all_min_d & (step_d == MIN_RUN);
      end else begin
        all_min_d = all_min_d & (spd_q[i] == MIN_RUN);
      end
    end
  end

  // Frame timing, command capture, arming FSM and the per-frame update pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      frm_cnt_q  <= '0;
      frm_tick_q <= 1'b0;
      arm_cnt_q  <= '0;
      pass_act_q <= 1'b0;
      pass_idx_q <= '0;
      armed_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        spd_q[i] <= '0;
        tgt_q[i] <= MIN_RUN;
      end
    end else begin
      frm_cnt_q  <= frm_cnt_q + FRM_ONE;
      frm_tick_q <= (frm_cnt_q == TICK_PRE);

      if (bus.cmd_vld) begin
        for (int i = 0; i < 4; i++) begin
          tgt_q[i] <= clamp_min(cmd_w[i]);
        end
      end

      if (state_q == IDLE || !bus.arm) begin
        // Idle or disarm: motors off, any pass in progress abandoned.
        for (int i = 0; i < 4; i++) begin
          spd_q[i] <= '0;
        end
        armed_q    <= 1'b0;
        pass_act_q <= 1'b0;
        pass_idx_q <= '0;
        if (state_q == IDLE && bus.arm) begin
          state_q   <= ARM_WAIT;
          arm_cnt_q <= '0;
        end else begin
          state_q <= IDLE;
        end
      end else begin
        case (state_q)
          ARM_WAIT: begin
            // The frame that completes the count gets no pass.
            if (frm_tick_q) begin
              arm_cnt_q <= arm_cnt_q + 16'd1;
              if (arm_cnt_q + 16'd1 == ARM_FRAMES) begin
                state_q <= SPIN;
              end
            end
          end
          default: begin
            if (pass_act_q) begin
              spd_q[pass_idx_q] <= step_d;
              pass_idx_q        <= pass_idx_q + 2'd1;
              if (pass_idx_q == 2'd3) begin
                pass_act_q <= 1'b0;
                if (state_q == SPIN && all_min_d) begin
                  state_q <= RUN;
                  armed_q <= 1'b1;
                end
              end
            end
            if (frm_tick_q) begin
              pass_act_q <= 1'b1;
              pass_idx_q <= '0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_esc_sequencer.sv
// Bench for esc_sequencer: directed arming, slew, stagger, collision, disarm and reset scenarios.
// Stimulus pushes each expected output change (value plus cycle offset from frm_tick) into a queue.
// A monitor pops and compares whenever any speed or armed output changes.
module tb_esc_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  esc_sequencer_if bus();

  esc_sequencer #(
    .FRAME_WIDTH(6),
    .ARM_FRAMES (16'd3),
    .MIN_RUN    (11'h200),
    .SLEW       (11'h040)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic [3:0][10:0] spd;
    logic             armed;
  } obs_t;

  typedef struct {
    obs_t o;
    int   off;
  } ev_t;

  ev_t  exp_q[$];
  obs_t model;
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t sample();
    obs_t s;
    s.spd[0] = bus.frnt_spd;
    s.spd[1] = bus.bck_spd;
    s.spd[2] = bus.lft_spd;
    s.spd[3] = bus.rght_spd;
    s.armed  = bus.armed;
    return s;
  endfunction

  // Expect channel ch to change to v at offset off cycles after the tick (off < 0: any time).
  task automatic push_ch(input int ch, input logic [10:0] v, input logic a, input int off);
    ev_t e;
    model.spd[ch] = v;
    model.armed   = a;
    e.o   = model;
    e.off = off;
    exp_q.push_back(e);
  endtask

  task automatic push_zero(input int off);
    ev_t e;
    model = '0;
    e.o   = model;
    e.off = off;
    exp_q.push_back(e);
  endtask

  // One spin-up pass: all four channels step to v, staggered T+2..T+5.
  task automatic push_pass(input logic [10:0] v, input logic last);
    for (int ch = 0; ch < 4; ch++) begin
      push_ch(ch, v, last && (ch == 3), 2 + ch);
    end
  endtask

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frm_tick !== 1'b1 && n < 200);
    if (bus.frm_tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no frm_tick within 200 cycles");
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_cmd(input logic [10:0] f, input logic [10:0] b,
                           input logic [10:0] l, input logic [10:0] r);
    bus.frnt_cmd = f;
    bus.bck_cmd  = b;
    bus.lft_cmd  = l;
    bus.rght_cmd = r;
    bus.cmd_vld  = 1'b1;
    @(negedge clk);
    bus.cmd_vld  = 1'b0;
  endtask

  // Monitor: every observed output change must match the next expected event.
  initial begin : monitor
    obs_t prev;
    obs_t cur;
    ev_t  e;
    int   age;
    int   evn;
    age = 100;
    evn = 0;
    wait (rst_n === 1'b0);
    wait (rst_n === 1'b1);
    @(negedge clk);
    prev = sample();
    forever begin
      @(negedge clk);
      if (bus.frm_tick === 1'b1) age = 0;
      else age++;
      cur = sample();
      if (cur !== prev) begin
        checks++;
        evn++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change%0d: got spd=%h armed=%b at tick+%0d, no change expected",
                   evn, cur.spd, cur.armed, age);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.o || (e.off >= 0 && age != e.off)) begin
            errors++;
            $display("FAIL event%0d: got spd=%h armed=%b at tick+%0d, expected spd=%h armed=%b at tick+%0d",
                     evn, cur.spd, cur.armed, age, e.o.spd, e.o.armed, e.off);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin : stim
    bus.arm      = 1'b0;
    bus.cmd_vld  = 1'b0;
    bus.frnt_cmd = '0;
    bus.bck_cmd  = '0;
    bus.lft_cmd  = '0;
    bus.rght_cmd = '0;
    model        = '0;

    // Reset state
    #2 rst_n = 1'b0;
    #2;
    chk("rst_frnt", bus.frnt_spd, 11'h000);
    chk("rst_bck", bus.bck_spd, 11'h000);
    chk("rst_lft", bus.lft_spd, 11'h000);
    chk("rst_rght", bus.rght_spd, 11'h000);
    chk("rst_armed", {10'b0, bus.armed}, 11'h000);
    chk("rst_tick", {10'b0, bus.frm_tick}, 11'h000);
    wait_neg(2);
    rst_n   = 1'b1;
    bus.arm = 1'b1;

    // Arm sequence: 3 silent frames, then 8 spin-up passes, armed at T+5 of the last
    for (int p = 1; p <= 8; p++) begin
      push_pass(11'(p * 64), p == 8);
    end
    repeat (3) wait_tick();
    wait_neg(10);
    chk("armwait_zero", bus.frnt_spd, 11'h000);
    repeat (8) wait_tick();
    wait_neg(8);
    chk("armed_run", {10'b0, bus.armed}, 11'h001);

    // Run slew on frnt
    wait_tick();
    wait_neg(10);
    push_ch(0, 11'h240, 1'b1, 2);
    push_ch(0, 11'h280, 1'b1, 2);
    push_ch(0, 11'h2C0, 1'b1, 2);
    push_ch(0, 11'h300, 1'b1, 2);
    pulse_cmd(11'h300, 11'h200, 11'h200, 11'h200);
    repeat (5) wait_tick();
    wait_neg(10);
    chk("frnt_hold", bus.frnt_spd, 11'h300);

    // Stagger: bck/lft/rght ramp together, updates land at T+3/T+4/T+5
    for (int s = 1; s <= 4; s++) begin
      for (int ch = 1; ch < 4; ch++) begin
        push_ch(ch, 11'(32'h200 + s * 64), 1'b1, 2 + ch);
      end
    end
    pulse_cmd(11'h300, 11'h300, 11'h300, 11'h300);
    repeat (4) wait_tick();
    wait_neg(10);
    chk("rght_up", bus.rght_spd, 11'h300);

    // Low command clamps to MIN_RUN
    for (int s = 1; s <= 4; s++) begin
      push_ch(1, 11'(32'h300 - s * 64), 1'b1, 3);
    end
    pulse_cmd(11'h300, 11'h050, 11'h300, 11'h300);
    repeat (5) wait_tick();
    wait_neg(10);
    chk("bck_clamp", bus.bck_spd, 11'h200);

    // Command collision with the lft slot at T+3
    wait_tick();
    wait_neg(3);
    pulse_cmd(11'h300, 11'h050, 11'h400, 11'h300);
    wait_neg(2);
    chk("lft_collide", bus.lft_spd, 11'h300);
    push_ch(2, 11'h340, 1'b1, 4);
    wait_tick();
    wait_neg(10);
    chk("lft_next", bus.lft_spd, 11'h340);

    // Disarm at T+2 of a run pass
    wait_tick();
    wait_neg(2);
    push_zero(3);
    bus.arm = 1'b0;
    @(negedge clk);
    chk("disarm_armed", {10'b0, bus.armed}, 11'h000);
    chk("disarm_frnt", bus.frnt_spd, 11'h000);
    wait_neg(7);
    bus.arm = 1'b1;
    push_pass(11'h040, 1'b0);
    repeat (3) wait_tick();
    wait_neg(10);
    chk("rearm_zero", bus.lft_spd, 11'h000);
    wait_tick();
    wait_neg(10);

    // Async reset in the tick cycle of a SPIN frame
    wait_tick();
    push_zero(-1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_frnt", bus.frnt_spd, 11'h000);
    chk("arst_bck", bus.bck_spd, 11'h000);
    chk("arst_lft", bus.lft_spd, 11'h000);
    chk("arst_rght", bus.rght_spd, 11'h000);
    chk("arst_armed", {10'b0, bus.armed}, 11'h000);
    chk("arst_tick", {10'b0, bus.frm_tick}, 11'h000);
    wait_neg(3);
    rst_n = 1'b1;
    push_pass(11'h040, 1'b0);
    repeat (3) wait_tick();
    chk("restart_zero", bus.rght_spd, 11'h000);
    wait_tick();
    wait_neg(10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d events still outstanding, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
